// File: rtl/spi_slave_rx_stream.sv
`timescale 1ns/1ps
// SPI slave receiver: CPOL/CPHA mode, MSB/LSB order, 1/2/4 lanes, any word width.
// Frames are tracked on chip-select and completed words are queued in a
// first-word-fall-through FIFO with a valid/ready handshake.
module spi_slave_rx_stream #(
  parameter int unsigned P_LANES      = 1,
  parameter int unsigned P_WORD_WIDTH = 8,
  parameter int unsigned P_CPOL       = 0,
  parameter int unsigned P_CPHA       = 0,
  parameter int unsigned P_MSB_FIRST  = 1,
  parameter int unsigned P_FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [P_LANES-1:0]              spi_mosi,
  input  logic                            spi_sclk,
  input  logic                            spi_ss_n,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [P_WORD_WIDTH-1:0]         m_data,
  output logic                            m_first,
  output logic                            frame_done,
  output logic [15:0]                     frame_words,
  output logic                            err_partial,
  output logic                            overflow,
  input  logic                            ovf_clr,
  output logic [$clog2(P_FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LP_CNT_W = $clog2(P_WORD_WIDTH + 1);
  localparam int unsigned LP_AW    = $clog2(P_FIFO_DEPTH);
  localparam int unsigned LP_PW    = LP_AW + 1;
  localparam logic        LP_SCLK_IDLE = (P_CPOL != 0);
  localparam logic [LP_CNT_W-1:0] LP_CNT_LANES = LP_CNT_W'(P_LANES);
  localparam logic [LP_CNT_W-1:0] LP_CNT_WORD  = LP_CNT_W'(P_WORD_WIDTH);
  localparam logic [LP_PW-1:0]    LP_DEPTH     = LP_PW'(P_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE} state_t;

  // Synchronizer chains
  logic                     r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic                     r_ss_s1, r_ss_s2, r_ss_d;
  logic [P_LANES-1:0]       r_mosi_s1, r_mosi_s2, r_mosi_d;
  logic [1:0]               r_prime;

  state_t                   r_state, w_state_next;

  logic [P_WORD_WIDTH-1:0]  r_shift;
  logic [LP_CNT_W-1:0]      r_bit_cnt;
  logic [15:0]              r_word_cnt;
  logic                     r_first_pending;
  logic                     r_push;
  logic [P_WORD_WIDTH-1:0]  r_push_data;
  logic                     r_push_first;
  logic                     r_frame_done;
  logic [15:0]              r_frame_words;
  logic                     r_err_partial;
  logic                     r_overflow;

  logic [P_WORD_WIDTH-1:0]  r_mem_data [P_FIFO_DEPTH];
  logic                     r_mem_first [P_FIFO_DEPTH];
  logic [LP_PW-1:0]         r_wptr, r_rptr;

  logic                     w_sclk_edge, w_lead, w_trail, w_sample_edge;
  logic                     w_ss_fall, w_ss_rise, w_sample;
  logic [P_WORD_WIDTH-1:0]  w_shift_next;
  logic [LP_CNT_W-1:0]      w_bit_cnt_next;
  logic                     w_word_done;
  logic [LP_PW-1:0]         w_level;
  logic                     w_full, w_empty, w_pop, w_wr, w_drop;

  // Two-flop synchronizers plus one delay flop on every SPI input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= LP_SCLK_IDLE;
      r_sclk_s2 <= LP_SCLK_IDLE;
      r_sclk_d  <= LP_SCLK_IDLE;
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_ss_d    <= 1'b1;
      r_mosi_s1 <= '0;
      r_mosi_s2 <= '0;
      r_mosi_d  <= '0;
    end else begin
      r_sclk_s1 <= spi_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_ss_s1   <= spi_ss_n;
      r_ss_s2   <= r_ss_s1;
      r_ss_d    <= r_ss_s2;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_mosi_d  <= r_mosi_s2;
    end
  end

  // The SS chain resets to 1, so IDLE must not trust it until real input has
  // filled the pipeline; otherwise a CS held low through reset would look like
  // a high-then-low sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_prime <= '0;
    else if (r_prime != 2'd3) r_prime <= r_prime + 2'd1;
  end

  assign w_sclk_edge   = r_sclk_s2 ^ r_sclk_d;
  assign w_lead        = w_sclk_edge && (r_sclk_s2 != LP_SCLK_IDLE);
  assign w_trail       = w_sclk_edge && (r_sclk_s2 == LP_SCLK_IDLE);
  assign w_sample_edge = (P_CPHA != 0) ? w_trail : w_lead;
  assign w_ss_fall     = r_ss_d && !r_ss_s2;
  assign w_ss_rise     = !r_ss_d && r_ss_s2;
  assign w_sample      = (r_state == S_ACTIVE) && w_sample_edge && !w_ss_rise;

  generate
    if (P_WORD_WIDTH == P_LANES) begin : g_shift_whole
      assign w_shift_next = r_mosi_d;
    end else if (P_MSB_FIRST != 0) begin : g_shift_msb
      assign w_shift_next = {r_shift[P_WORD_WIDTH-P_LANES-1:0], r_mosi_d};
    end else begin : g_shift_lsb
      assign w_shift_next = {r_mosi_d, r_shift[P_WORD_WIDTH-1:P_LANES]};
    end
  endgenerate

  assign w_bit_cnt_next = r_bit_cnt + LP_CNT_LANES;
  assign w_word_done    = (w_bit_cnt_next == LP_CNT_WORD);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: frame tracking on chip-select
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if ((r_prime == 2'd3) && r_ss_s2) w_state_next = S_ARMED;
      S_ARMED:  if (w_ss_fall)                    w_state_next = S_ACTIVE;
      S_ACTIVE: if (w_ss_rise)                    w_state_next = S_ARMED;
      default:                                    w_state_next = S_IDLE;
    endcase
  end

  // Shift register, bit/word counters and frame-end reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift         <= '0;
      r_bit_cnt       <= '0;
      r_word_cnt      <= '0;
      r_first_pending <= 1'b0;
      r_push          <= 1'b0;
      r_push_data     <= '0;
      r_push_first    <= 1'b0;
      r_frame_done    <= 1'b0;
      r_frame_words   <= '0;
      r_err_partial   <= 1'b0;
    end else begin
      r_push        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err_partial <= 1'b0;
      if ((r_state == S_ARMED) && w_ss_fall) begin
        r_shift         <= '0;
        r_bit_cnt       <= '0;
        r_word_cnt      <= '0;
        r_first_pending <= 1'b1;
      end else if ((r_state == S_ACTIVE) && w_ss_rise) begin
        r_frame_done  <= 1'b1;
        r_frame_words <= r_word_cnt;
        r_err_partial <= (r_bit_cnt != '0);
        r_bit_cnt     <= '0;
      end else if (w_sample) begin
        r_shift <= w_shift_next;
        if (w_word_done) begin
          r_push          <= 1'b1;
          r_push_data     <= w_shift_next;
          r_push_first    <= r_first_pending;
          r_first_pending <= 1'b0;
          r_bit_cnt       <= '0;
          if (r_word_cnt != 16'hFFFF) r_word_cnt <= r_word_cnt + 16'd1;
        end else begin
          r_bit_cnt <= w_bit_cnt_next;
        end
      end
    end
  end

  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == LP_DEPTH);
  assign w_empty = (w_level == '0);
  assign w_pop   = !w_empty && m_ready;
  assign w_wr    = r_push && (!w_full || w_pop);
  assign w_drop  = r_push && w_full && !w_pop;

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < P_FIFO_DEPTH; i++) begin
        r_mem_data[i]  <= '0;
        r_mem_first[i] <= 1'b0;
      end
    end else begin
      if (w_wr) begin
        r_mem_data[r_wptr[LP_AW-1:0]]  <= r_push_data;
        r_mem_first[r_wptr[LP_AW-1:0]] <= r_push_first;
        r_wptr <= r_wptr + LP_PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + LP_PW'(1);
    end
  end

  // Sticky overflow; a new drop takes priority over a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

  assign m_valid     = !w_empty;
  assign m_data      = r_mem_data[r_rptr[LP_AW-1:0]];
  assign m_first     = r_mem_first[r_rptr[LP_AW-1:0]];
  assign frame_done  = r_frame_done;
  assign frame_words = r_frame_words;
  assign err_partial = r_err_partial;
  assign overflow    = r_overflow;
  assign fifo_level  = w_level;

endmodule

// File: tb/tb_spi_slave_rx_stream.sv
`timescale 1ns/1ps
// Directed bench for spi_slave_rx_stream: three instances cover mode 0 default,
// mode 3 / LSB-first / 4-lane / 16-bit, and a 4-deep FIFO.
module tb_spi_slave_rx_stream;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared mode-0 bus for u0 and u2 (separate chip-selects)
  logic       sclk, mosi, ss0_n, ss2_n;
  // Mode-3 4-lane bus for u1
  logic       sclk1, ss1_n;
  logic [3:0] mosi1;

  logic        v0, rdy0, first0, fd0, ep0, ovf0, ovfclr0;
  logic [7:0]  data0;
  logic [15:0] fw0;
  logic [4:0]  lvl0;

  logic        v1, rdy1, first1, fd1, ep1, ovf1, ovfclr1;
  logic [15:0] data1, fw1;
  logic [4:0]  lvl1;

  logic        v2, rdy2, first2, fd2, ep2, ovf2, ovfclr2;
  logic [7:0]  data2;
  logic [15:0] fw2;
  logic [2:0]  lvl2;

  spi_slave_rx_stream u0 (
    .clk(clk), .rst_n(rst_n), .spi_mosi(mosi), .spi_sclk(sclk), .spi_ss_n(ss0_n),
    .m_valid(v0), .m_ready(rdy0), .m_data(data0), .m_first(first0),
    .frame_done(fd0), .frame_words(fw0), .err_partial(ep0), .overflow(ovf0),
    .ovf_clr(ovfclr0), .fifo_level(lvl0)
  );

  spi_slave_rx_stream #(
    .P_LANES(4), .P_WORD_WIDTH(16), .P_CPOL(1), .P_CPHA(1), .P_MSB_FIRST(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .spi_mosi(mosi1), .spi_sclk(sclk1), .spi_ss_n(ss1_n),
    .m_valid(v1), .m_ready(rdy1), .m_data(data1), .m_first(first1),
    .frame_done(fd1), .frame_words(fw1), .err_partial(ep1), .overflow(ovf1),
    .ovf_clr(ovfclr1), .fifo_level(lvl1)
  );

  spi_slave_rx_stream #(.P_FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .spi_mosi(mosi), .spi_sclk(sclk), .spi_ss_n(ss2_n),
    .m_valid(v2), .m_ready(rdy2), .m_data(data2), .m_first(first2),
    .frame_done(fd2), .frame_words(fw2), .err_partial(ep2), .overflow(ovf2),
    .ovf_clr(ovfclr2), .fifo_level(lvl2)
  );

  // Captured handshakes and frame-end reports
  logic [15:0] q0d[$], q1d[$], q2d[$];
  logic        q0f[$], q1f[$], q2f[$];
  logic [15:0] f0w[$], f1w[$], f2w[$];
  logic        f0e[$];
  int          ep0_cnt = 0;

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (v0 && rdy0) begin q0d.push_back(16'(data0)); q0f.push_back(first0); end
      if (fd0) begin f0w.push_back(fw0); f0e.push_back(ep0); end
      if (ep0) ep0_cnt++;
      if (v1 && rdy1) begin q1d.push_back(data1); q1f.push_back(first1); end
      if (fd1) f1w.push_back(fw1);
      if (v2 && rdy2) begin q2d.push_back(16'(data2)); q2f.push_back(first2); end
      if (fd2) f2w.push_back(fw2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    q0d.delete(); q0f.delete(); f0w.delete(); f0e.delete();
    q1d.delete(); q1f.delete(); f1w.delete();
    q2d.delete(); q2f.delete(); f2w.delete();
  endtask

  // Mode-0 transfer, MSB first; pop_last pulses rdy2 exactly in the cycle
  // where the final bit's word is pushed into u2's FIFO.
  task automatic send_bits(input logic [15:0] v, input int n, input bit pop_last);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      if (pop_last && i == 0) begin
        repeat (3) @(negedge clk);
        rdy2 = 1'b1;
        @(negedge clk);
        rdy2 = 1'b0;
      end else begin
        repeat (4) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  // Mode-3 nibble: data changes on the falling (leading) edge
  task automatic send_nib1(input logic [3:0] n);
    sclk1 = 1'b0;
    mosi1 = n;
    repeat (4) @(negedge clk);
    sclk1 = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    sclk = 1'b0; mosi = 1'b0; ss0_n = 1'b1; ss2_n = 1'b1;
    sclk1 = 1'b1; mosi1 = '0; ss1_n = 1'b1;
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    ovfclr0 = 1'b0; ovfclr1 = 1'b0; ovfclr2 = 1'b0;
    rst_n = 1'b0;
    wait_clk(3);

    chk("rst_valid", 32'(v0), 0);
    chk("rst_data", 32'(data0), 0);
    chk("rst_first", 32'(first0), 0);
    chk("rst_fdone", 32'(fd0), 0);
    chk("rst_fwords", 32'(fw0), 0);
    chk("rst_partial", 32'(ep0), 0);
    chk("rst_ovf", 32'(ovf0), 0);
    chk("rst_level", 32'(lvl0), 0);

    rst_n = 1'b1;
    wait_clk(8);

    // Two-byte frame, consumer always ready
    rdy0 = 1'b1;
    ss0_n = 1'b0; wait_clk(4);
    send_bits(16'hA5, 8, 1'b0);
    send_bits(16'h3C, 8, 1'b0);
    wait_clk(4); ss0_n = 1'b1; wait_clk(10);
    chk("t1_count", 32'(q0d.size()), 2);
    chk("t1_w0", 32'(q0d[0]), 32'hA5);
    chk("t1_f0", 32'(q0f[0]), 1);
    chk("t1_w1", 32'(q0d[1]), 32'h3C);
    chk("t1_f1", 32'(q0f[1]), 0);
    chk("t1_fdone_cnt", 32'(f0w.size()), 1);
    chk("t1_fwords", 32'(f0w[0]), 2);
    chk("t1_no_partial", 32'(ep0_cnt), 0);
    clear_q();

    // Three bytes plus five stray bits
    ss0_n = 1'b0; wait_clk(4);
    send_bits(16'h11, 8, 1'b0);
    send_bits(16'h22, 8, 1'b0);
    send_bits(16'h33, 8, 1'b0);
    send_bits(16'h16, 5, 1'b0);
    wait_clk(4); ss0_n = 1'b1; wait_clk(10);
    chk("t3_count", 32'(q0d.size()), 3);
    chk("t3_w0", 32'(q0d[0]), 32'h11);
    chk("t3_w1", 32'(q0d[1]), 32'h22);
    chk("t3_w2", 32'(q0d[2]), 32'h33);
    chk("t3_f0", 32'(q0f[0]), 1);
    chk("t3_f2", 32'(q0f[2]), 0);
    chk("t3_fwords", 32'(f0w[0]), 3);
    chk("t3_partial_with_fdone", 32'(f0e[0]), 1);
    chk("t3_partial_cnt", 32'(ep0_cnt), 1);
    clear_q();

    ss0_n = 1'b0; wait_clk(4);
    send_bits(16'h5A, 8, 1'b0);
    wait_clk(4); ss0_n = 1'b1; wait_clk(10);
    chk("t3b_count", 32'(q0d.size()), 1);
    chk("t3b_w0", 32'(q0d[0]), 32'h5A);
    chk("t3b_f0", 32'(q0f[0]), 1);
    chk("t3b_fwords", 32'(f0w[0]), 1);
    chk("t3b_no_partial", 32'(f0e[0]), 0);
    clear_q();

    // Back-pressure: head word must hold steady
    rdy0 = 1'b0;
    ss0_n = 1'b0; wait_clk(4);
    send_bits(16'hC3, 8, 1'b0);
    send_bits(16'h7E, 8, 1'b0);
    wait_clk(4); ss0_n = 1'b1; wait_clk(10);
    chk("hold_level", 32'(lvl0), 2);
    begin
      int unstable = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (v0 !== 1'b1 || data0 !== 8'hC3 || first0 !== 1'b1) unstable++;
      end
      chk("hold_stable", 32'(unstable), 0);
    end
    rdy0 = 1'b1; wait_clk(5);
    chk("hold_drain_cnt", 32'(q0d.size()), 2);
    chk("hold_drain_w1", 32'(q0d[1]), 32'h7E);
    chk("hold_drain_f1", 32'(q0f[1]), 0);
    chk("hold_drain_level", 32'(lvl0), 0);
    clear_q();

    // Mode 3, LSB first, 4 lanes, 16-bit word
    rdy1 = 1'b1;
    ss1_n = 1'b0; wait_clk(4);
    send_nib1(4'h1); send_nib1(4'h2); send_nib1(4'h3); send_nib1(4'h4);
    wait_clk(4); ss1_n = 1'b1; wait_clk(10);
    chk("q4_count", 32'(q1d.size()), 1);
    chk("q4_word", 32'(q1d[0]), 32'h4321);
    chk("q4_first", 32'(q1f[0]), 1);
    chk("q4_fwords", 32'(f1w[0]), 1);
    clear_q();

    // 4-deep FIFO overflow
    ss2_n = 1'b0; wait_clk(4);
    for (int b = 1; b <= 6; b++) send_bits(16'(b), 8, 1'b0);
    wait_clk(4); ss2_n = 1'b1; wait_clk(10);
    chk("ovf_level", 32'(lvl2), 4);
    chk("ovf_flag", 32'(ovf2), 1);
    chk("ovf_fwords", 32'(f2w[0]), 6);
    ovfclr2 = 1'b1; @(negedge clk); ovfclr2 = 1'b0; @(negedge clk);
    chk("ovf_clear", 32'(ovf2), 0);
    rdy2 = 1'b1; wait_clk(8); rdy2 = 1'b0;
    chk("ovf_drain_cnt", 32'(q2d.size()), 4);
    for (int k = 0; k < 4; k++) chk("ovf_drain_word", 32'(q2d[k]), 32'(k + 1));
    chk("ovf_drain_f0", 32'(q2f[0]), 1);
    chk("ovf_drain_f3", 32'(q2f[3]), 0);
    chk("ovf_drain_level", 32'(lvl2), 0);
    clear_q();

    // Full FIFO with pop and push in the same cycle
    ss2_n = 1'b0; wait_clk(4);
    for (int b = 16; b <= 19; b++) send_bits(16'(b), 8, 1'b0);
    chk("full_level", 32'(lvl2), 4);
    send_bits(16'h14, 8, 1'b1);
    chk("pushpop_level", 32'(lvl2), 4);
    chk("pushpop_no_ovf", 32'(ovf2), 0);
    chk("pushpop_popped", 32'(q2d[0]), 32'h10);
    wait_clk(4); ss2_n = 1'b1; wait_clk(10);
    rdy2 = 1'b1; wait_clk(8); rdy2 = 1'b0;
    chk("pushpop_total", 32'(q2d.size()), 5);
    chk("pushpop_w1", 32'(q2d[1]), 32'h11);
    chk("pushpop_w4", 32'(q2d[4]), 32'h14);
    clear_q();

    // Reset in the middle of a byte
    ss0_n = 1'b0; wait_clk(4);
    send_bits(16'hA, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(v0), 0);
    chk("mid_rst_level", 32'(lvl0), 0);
    chk("mid_rst_data", 32'(data0), 0);
    chk("mid_rst_fwords", 32'(fw0), 0);
    chk("mid_rst_fdone", 32'(fd0), 0);
    chk("mid_rst_partial", 32'(ep0), 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(8);
    send_bits(16'hFF, 8, 1'b0);
    wait_clk(10);
    chk("cs_low_at_rst_words", 32'(q0d.size()), 0);
    chk("cs_low_at_rst_level", 32'(lvl0), 0);
    chk("cs_low_at_rst_fdone", 32'(f0w.size()), 0);
    ss0_n = 1'b1; wait_clk(10);
    ss0_n = 1'b0; wait_clk(4);
    send_bits(16'h81, 8, 1'b0);
    wait_clk(4); ss0_n = 1'b1; wait_clk(10);
    chk("post_rst_count", 32'(q0d.size()), 1);
    chk("post_rst_word", 32'(q0d[0]), 32'h81);
    chk("post_rst_first", 32'(q0f[0]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
